// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mips_pkg
// Purpose  : Shared constants for the multicycle MIPS main control FSM:
//            opcode values, ALUOp encodings handed to alu_control, and the
//            4-bit state encoding (also exported on the debug state port).
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package mips_pkg;

  // Opcodes (IR[31:26]) understood by the decoder.
  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_J     = 6'd2;
  localparam logic [5:0] OP_BEQ   = 6'd4;
  localparam logic [5:0] OP_ADDI  = 6'd8;
  localparam logic [5:0] OP_LUI   = 6'd15;
  localparam logic [5:0] OP_LW    = 6'd35;
  localparam logic [5:0] OP_SW    = 6'd43;

  // ALUOp encodings consumed by alu_control.
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_LUI   = 2'b11;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMRD    = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWR    = 4'd5,
    S_EXEC     = 4'd6,
    S_RTYPE_WB = 4'd7,
    S_BRANCH   = 4'd8,
    S_ADDI_EX  = 4'd9,
    S_IMM_WB   = 4'd10,
    S_LUI_EX   = 4'd11,
    S_JUMP     = 4'd12,
    S_TRAP     = 4'd13
  } state_e;

  // States that hold a memory access open until mem_ready.
  function automatic logic is_mem_state(input state_e s);
    return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
  endfunction

endpackage
`default_nettype wire

// File: rtl/mips_multicycle_control_if.sv
`default_nettype none
// ============================================================================
// Module   : mips_multicycle_control_if
// Purpose  : Bundle between the main control FSM and the datapath.
//            master = controller (drives control lines, reads status),
//            slave  = datapath  (drives opcode/zero/mem_ready).
// Signals  : opcode, zero, mem_ready (datapath -> control)
//            ALUOp, pc_en, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
//            RegDst, RegWrite, ALUSrcA, ALUSrcB, PCSource, state,
//            mem_timeout (control -> datapath)
// Revision : 1.0 - initial release
// ============================================================================
interface mips_multicycle_control_if;
  logic [5:0] opcode;
  logic       zero;
  logic       mem_ready;
  logic [1:0] ALUOp;
  logic       pc_en;
  logic       IorD;
  logic       MemRead;
  logic       MemWrite;
  logic       IRWrite;
  logic       MemtoReg;
  logic       RegDst;
  logic       RegWrite;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] PCSource;
  logic [3:0] state;
  logic       mem_timeout;

  modport master (
    input  opcode, zero, mem_ready,
    output ALUOp, pc_en, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
           RegDst, RegWrite, ALUSrcA, ALUSrcB, PCSource, state, mem_timeout
  );

  modport slave (
    output opcode, zero, mem_ready,
    input  ALUOp, pc_en, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
           RegDst, RegWrite, ALUSrcA, ALUSrcB, PCSource, state, mem_timeout
  );
endinterface
`default_nettype wire

// File: rtl/mips_stall_counter.sv
`default_nettype none
// ============================================================================
// Module   : mips_stall_counter
// Purpose  : 8-bit saturating count of consecutive stalled memory cycles.
//            timeout_o is sticky: it sets on the edge where the count
//            reaches LIMIT and only rst clears it.
// Ports    : clk, rst  - clock, synchronous active-high reset
//            stall_i   - controller sits in a memory state without mem_ready
//            clear_i   - controller changes state this cycle
//            timeout_o - sticky stall-limit flag
// Revision : 1.0 - initial release
// ============================================================================
module mips_stall_counter #(
  parameter int unsigned LIMIT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic stall_i,
  input  logic clear_i,
  output logic timeout_o
);

  localparam logic [7:0] LIMIT_C = 8'(LIMIT);

  logic [7:0] count_q, count_d;
  logic       timeout_q, timeout_d;

  always_comb begin
    count_d   = count_q;
    timeout_d = timeout_q;
    if (clear_i) begin
      count_d = '0;
    end else if (stall_i && (count_q != LIMIT_C)) begin
      count_d = count_q + 8'd1;
    end
    if (count_d == LIMIT_C) begin
      timeout_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q   <= '0;
      timeout_q <= 1'b0;
    end else begin
      count_q   <= count_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout_o = timeout_q;

endmodule
`default_nettype wire

// File: rtl/mips_multicycle_control.sv
`default_nettype none
// ============================================================================
// Module   : mips_multicycle_control
// Purpose  : Multicycle MIPS main control FSM (Moore decode of a 4-bit
//            state), sequencing FETCH/DECODE/EXEC/MEM/WB and driving the
//            datapath enables and ALUOp for alu_control.
// Ports    : clk, rst - clock, synchronous active-high reset
//            ctrl     - mips_multicycle_control_if.master bundle
//            illegal_op (ILLEGAL_TRAP_EN only) - high while in TRAP
// Options  : ILLEGAL_TRAP_EN - illegal opcode parks the FSM in TRAP until
//            rst; otherwise the instruction is dropped (NOP).
// Revision : 1.0 - initial release
// ============================================================================
module mips_multicycle_control
  import mips_pkg::*;
#(
  parameter int unsigned MEM_WAIT_LIMIT = 15
) (
  input logic clk,
  input logic rst,
  mips_multicycle_control_if.master ctrl
`ifdef ILLEGAL_TRAP_EN
  ,
  output logic illegal_op
`endif
);

  state_e     state_q, state_d;
  logic [1:0] alu_op, alusrcb, pcsource;
  logic       pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
  logic       memtoreg, regdst, regwrite, alusrca;

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_FETCH;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d       = state_q;
    alu_op        = ALUOP_ADD;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    iord          = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    memtoreg      = 1'b0;
    regdst        = 1'b0;
    regwrite      = 1'b0;
    alusrca       = 1'b0;
    alusrcb       = 2'b00;
    pcsource      = 2'b00;
    unique case (state_q)
      S_FETCH: begin
        mem_read = 1'b1;
        alusrcb  = 2'b01;
        // PC+4 and IR load commit only in the cycle memory delivers.
        ir_write = ctrl.mem_ready;
        pc_write = ctrl.mem_ready;
        if (ctrl.mem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        alusrcb = 2'b11;  // speculative branch target into ALUOut
        case (ctrl.opcode)
          OP_RTYPE:      state_d = S_EXEC;
          OP_LW, OP_SW:  state_d = S_MEMADR;
          OP_BEQ:        state_d = S_BRANCH;
          OP_ADDI:       state_d = S_ADDI_EX;
          OP_LUI:        state_d = S_LUI_EX;
          OP_J:          state_d = S_JUMP;
`ifdef ILLEGAL_TRAP_EN
          default:       state_d = S_TRAP;
`else
          default:       state_d = S_FETCH;
`endif
        endcase
      end
      S_MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        state_d = (ctrl.opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
        if (ctrl.mem_ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        regwrite = 1'b1;
        memtoreg = 1'b1;
        state_d  = S_FETCH;
      end
      S_MEMWR: begin
        // Request held until ready; leaving on ready means one commit.
        mem_write = 1'b1;
        iord      = 1'b1;
        if (ctrl.mem_ready) state_d = S_FETCH;
      end
      S_EXEC: begin
        alusrca = 1'b1;
        alu_op  = ALUOP_FUNCT;
        state_d = S_RTYPE_WB;
      end
      S_RTYPE_WB: begin
        regwrite = 1'b1;
        regdst   = 1'b1;
        state_d  = S_FETCH;
      end
      S_BRANCH: begin
        alusrca       = 1'b1;
        alu_op        = ALUOP_SUB;
        pcsource      = 2'b01;
        pc_write_cond = 1'b1;
        state_d       = S_FETCH;
      end
      S_ADDI_EX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        state_d = S_IMM_WB;
      end
      S_IMM_WB: begin
        regwrite = 1'b1;
        state_d  = S_FETCH;
      end
      S_LUI_EX: begin
        alusrcb = 2'b10;
        alu_op  = ALUOP_LUI;
        state_d = S_IMM_WB;
      end
      S_JUMP: begin
        pcsource = 2'b10;
        pc_write = 1'b1;
        state_d  = S_FETCH;
      end
`ifdef ILLEGAL_TRAP_EN
      S_TRAP: state_d = S_TRAP;
`endif
      default: state_d = S_FETCH;
    endcase
  end

  // Architectural side effects are suppressed while rst is held so a reset
  // landing mid-instruction cannot leave a partial writeback behind.
  assign ctrl.pc_en    = ~rst & (pc_write | (pc_write_cond & ctrl.zero));
  assign ctrl.MemWrite = ~rst & mem_write;
  assign ctrl.IRWrite  = ~rst & ir_write;
  assign ctrl.RegWrite = ~rst & regwrite;
  assign ctrl.ALUOp    = alu_op;
  assign ctrl.IorD     = iord;
  assign ctrl.MemRead  = mem_read;
  assign ctrl.MemtoReg = memtoreg;
  assign ctrl.RegDst   = regdst;
  assign ctrl.ALUSrcA  = alusrca;
  assign ctrl.ALUSrcB  = alusrcb;
  assign ctrl.PCSource = pcsource;
  assign ctrl.state    = state_q;

`ifdef ILLEGAL_TRAP_EN
  assign illegal_op = (state_q == S_TRAP);
`endif

  mips_stall_counter #(
    .LIMIT (MEM_WAIT_LIMIT)
  ) u_stall (
    .clk       (clk),
    .rst       (rst),
    .stall_i   (is_mem_state(state_q) && !ctrl.mem_ready),
    .clear_i   (state_d != state_q),
    .timeout_o (ctrl.mem_timeout)
  );

endmodule
`default_nettype wire

// File: tb/tb_mips_multicycle_control.sv
`default_nettype none
// ============================================================================
// Module   : tb_mips_multicycle_control
// Purpose  : Directed self-checking bench for mips_multicycle_control.
//            Inputs change 1 ns after the rising edge; outputs are read
//            there too, so each check sees the state entered on that edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mips_multicycle_control;

  logic clk = 1'b0;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  mips_multicycle_control_if bus ();

`ifdef ILLEGAL_TRAP_EN
  logic illegal_op;
`endif

  mips_multicycle_control #(
    .MEM_WAIT_LIMIT (15)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .ctrl (bus.master)
`ifdef ILLEGAL_TRAP_EN
    ,
    .illegal_op (illegal_op)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst           = 1'b1;
    bus.opcode    = 6'd0;
    bus.zero      = 1'b0;
    bus.mem_ready = 1'b1;
    tick();
    tick();
    // In FETCH with mem_ready=1, but reset must mask the enables.
    check("rst_state",   bus.state, 0);
    check("rst_pc_en",   bus.pc_en, 0);
    check("rst_irwrite", bus.IRWrite, 0);
    check("rst_timeout", bus.mem_timeout, 0);
    rst = 1'b0;
    #1;
    check("fetch_pc_en",   bus.pc_en, 1);
    check("fetch_irwrite", bus.IRWrite, 1);
    check("fetch_memread", bus.MemRead, 1);
    check("fetch_srcb",    bus.ALUSrcB, 2'b01);

    // R-type: 0 -> 1 -> 6 -> 7 -> 0
    tick(); check("r_decode", bus.state, 1);
    check("r_decode_srcb", bus.ALUSrcB, 2'b11);
    tick(); check("r_exec", bus.state, 6);
    check("r_exec_aluop", bus.ALUOp, 2'b10);
    check("r_exec_srca",  bus.ALUSrcA, 1);
    tick(); check("r_wb", bus.state, 7);
    check("r_wb_regwrite", bus.RegWrite, 1);
    check("r_wb_regdst",   bus.RegDst, 1);
    tick(); check("r_back_fetch", bus.state, 0);

    // LW with three stalled MEMRD cycles.
    bus.opcode = 6'd35;
    tick(); check("lw_decode", bus.state, 1);
    tick(); check("lw_memadr", bus.state, 2);
    check("lw_memadr_srcb", bus.ALUSrcB, 2'b10);
    bus.mem_ready = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) begin
      check("lw_memrd_hold", bus.state, 3);
      check("lw_memrd_read", bus.MemRead, 1);
      check("lw_memrd_iord", bus.IorD, 1);
      tick();
    end
    bus.mem_ready = 1'b1;
    #1;
    check("lw_memrd_last", bus.state, 3);
    tick(); check("lw_memwb", bus.state, 4);
    check("lw_memwb_regwrite", bus.RegWrite, 1);
    check("lw_memwb_memtoreg", bus.MemtoReg, 1);
    check("lw_memwb_regdst",   bus.RegDst, 0);
    tick(); check("lw_back_fetch", bus.state, 0);

    // SW with one stalled MEMWR cycle.
    bus.opcode = 6'd43;
    tick(); tick();
    bus.mem_ready = 1'b0;
    tick(); check("sw_memwr", bus.state, 5);
    check("sw_memwrite", bus.MemWrite, 1);
    tick(); check("sw_memwr_hold", bus.state, 5);
    bus.mem_ready = 1'b1;
    tick(); check("sw_back_fetch", bus.state, 0);
    check("sw_memwrite_off", bus.MemWrite, 0);

    // BEQ taken then not taken.
    bus.opcode = 6'd4;
    bus.zero   = 1'b1;
    tick(); tick(); check("beq1_state", bus.state, 8);
    check("beq1_pc_en",  bus.pc_en, 1);
    check("beq1_aluop",  bus.ALUOp, 2'b01);
    check("beq1_pcsrc",  bus.PCSource, 2'b01);
    tick();
    bus.zero = 1'b0;
    tick(); tick(); check("beq0_state", bus.state, 8);
    check("beq0_pc_en",  bus.pc_en, 0);
    check("beq0_aluop",  bus.ALUOp, 2'b01);
    check("beq0_pcsrc",  bus.PCSource, 2'b01);
    tick();

    // LUI then ADDI.
    bus.opcode = 6'd15;
    tick(); tick(); check("lui_state", bus.state, 11);
    check("lui_aluop", bus.ALUOp, 2'b11);
    check("lui_srcb",  bus.ALUSrcB, 2'b10);
    check("lui_srca",  bus.ALUSrcA, 0);
    tick(); check("lui_wb", bus.state, 10);
    check("lui_wb_regwrite", bus.RegWrite, 1);
    check("lui_wb_memtoreg", bus.MemtoReg, 0);
    tick();
    bus.opcode = 6'd8;
    tick(); tick(); check("addi_state", bus.state, 9);
    check("addi_aluop", bus.ALUOp, 2'b00);
    check("addi_srca",  bus.ALUSrcA, 1);
    tick(); check("addi_wb", bus.state, 10);
    check("addi_wb_regwrite", bus.RegWrite, 1);
    tick(); check("addi_back_fetch", bus.state, 0);

    // Jump.
    bus.opcode = 6'd2;
    tick(); tick(); check("j_state", bus.state, 12);
    check("j_pc_en", bus.pc_en, 1);
    check("j_pcsrc", bus.PCSource, 2'b10);
    tick(); check("j_back_fetch", bus.state, 0);

    // FETCH stall: timeout after the 15th stalled cycle, sticky after.
    bus.opcode    = 6'd8;
    bus.mem_ready = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (k == 14) check("to_before", bus.mem_timeout, 0);
      if (k == 15) check("to_at",     bus.mem_timeout, 1);
      if (k == 20) begin
        check("to_hold",  bus.mem_timeout, 1);
        check("to_state", bus.state, 0);
      end
    end
    bus.mem_ready = 1'b1;
    tick(); check("to_sticky", bus.mem_timeout, 1);
    check("to_decode", bus.state, 1);
    rst = 1'b1;
    tick(); check("to_rst_flag",  bus.mem_timeout, 0);
    check("to_rst_state", bus.state, 0);
    rst = 1'b0;

    // Reset landing in RTYPE_WB must mask RegWrite.
    bus.opcode = 6'd0;
    tick(); tick(); tick(); check("mid_wb_state", bus.state, 7);
    rst = 1'b1;
    #1;
    check("mid_rst_regwrite", bus.RegWrite, 0);
    tick(); check("mid_rst_state", bus.state, 0);
    rst = 1'b0;

    // Illegal opcode.
    bus.opcode = 6'd63;
    tick(); check("ill_decode", bus.state, 1);
    check("ill_dec_regwrite", bus.RegWrite, 0);
    check("ill_dec_memwrite", bus.MemWrite, 0);
    tick();
`ifdef ILLEGAL_TRAP_EN
    for (int k = 0; k < 10; k++) begin
      check("trap_state", bus.state, 13);
      check("trap_flag",  illegal_op, 1);
      check("trap_pc_en", bus.pc_en, 0);
      tick();
    end
    rst = 1'b1;
    tick(); check("trap_rst_state", bus.state, 0);
    check("trap_rst_flag", illegal_op, 0);
    rst = 1'b0;
`else
    check("ill_nop_state", bus.state, 0);
    check("ill_nop_regwrite", bus.RegWrite, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
